// File: rtl/key_unlock_loader.sv
// Serial key loader for the key-locked counter core: shifts in a parity-protected
// key frame, commits it to sk, and locks out after repeated parity failures.
module key_unlock_loader #(
  parameter int KEY_W       = 4,
  parameter int FAIL_MAX    = 3,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_start_i,
  input  logic             key_valid_i,
  input  logic             key_bit_i,
  output logic             key_ready_o,
  input  logic             enable_in_i,
  output logic [KEY_W-1:0] sk_o,
  output logic             core_enable_o,
  output logic             key_loaded_o,
  output logic             key_err_o,
  output logic             lockout_o
);

  localparam int CNT_W = $clog2(KEY_W + 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CHECK   = 3'd2,
    LOADED  = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [KEY_W:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       fail_cnt_q, fail_cnt_d;
  logic [3:0]       fail_inc;
  logic [7:0]       timer_q, timer_d;
  logic [KEY_W-1:0] sk_q, sk_d;
  logic             loaded_q, loaded_d;
  logic             err_q, err_d;
  logic             lock_q, lock_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      bit_cnt_q  <= '0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      sk_q       <= '0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      bit_cnt_q  <= bit_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      sk_q       <= sk_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      lock_q     <= lock_d;
    end
  end

  // Saturating increment so a pathological FAIL_MAX can never wrap the counter.
  assign fail_inc = (fail_cnt_q == 4'hF) ? fail_cnt_q : fail_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    bit_cnt_d  = bit_cnt_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    sk_d       = sk_q;
    loaded_d   = loaded_q;
    err_d      = 1'b0;
    lock_d     = lock_q;
    case (state_q)
      IDLE, LOADED: begin
        if (key_start_i) begin
          shadow_d  = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // A restart strobe wins over any bit presented on the same cycle.
        if (key_start_i) begin
          shadow_d  = '0;
          bit_cnt_d = '0;
        end else if (bit_cnt_q == CNT_W'(KEY_W + 1)) begin
          state_d = CHECK;
        end else if (key_valid_i) begin
          shadow_d  = {shadow_q[KEY_W-1:0], key_bit_i};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        if (^shadow_q == 1'b0) begin
          sk_d       = shadow_q[KEY_W:1];
          loaded_d   = 1'b1;
          fail_cnt_d = '0;
          state_d    = LOADED;
        end else begin
          err_d      = 1'b1;
          fail_cnt_d = fail_inc;
          if (fail_inc == 4'(FAIL_MAX)) begin
            sk_d     = '0;
            loaded_d = 1'b0;
            lock_d   = 1'b1;
            timer_d  = '0;
            state_d  = LOCKOUT;
          end else begin
            state_d = loaded_q ? LOADED : IDLE;
          end
        end
      end
      LOCKOUT: begin
        if (timer_q == 8'(LOCKOUT_CYC - 1)) begin
          fail_cnt_d = '0;
          lock_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_ready_o   = (state_q == IDLE) || (state_q == SHIFT) || (state_q == LOADED);
  assign sk_o          = sk_q;
  assign key_loaded_o  = loaded_q;
  assign core_enable_o = enable_in_i & loaded_q;
  assign key_err_o     = err_q;
  assign lockout_o     = lock_q;

endmodule

// File: tb/tb_key_unlock_loader.sv
// Bench for key_unlock_loader: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized frames.
module tb_key_unlock_loader;
  localparam int KW = 4, FM = 3, LC = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ks = 1'b0, kv = 1'b0, kb = 1'b0, en = 1'b0;
  logic key_ready, core_enable, key_loaded, key_err, lockout;
  logic [KW-1:0] sk;

  always #5 clk = ~clk;

  key_unlock_loader #(.KEY_W(KW), .FAIL_MAX(FM), .LOCKOUT_CYC(LC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .key_start_i(ks), .key_valid_i(kv), .key_bit_i(kb),
    .key_ready_o(key_ready), .enable_in_i(en), .sk_o(sk), .core_enable_o(core_enable),
    .key_loaded_o(key_loaded), .key_err_o(key_err), .lockout_o(lockout));

  int checks = 0, errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame collected as an integer, judged by popcount parity;
  // lockout expiry tracked as an absolute cycle number.
  localparam int MI = 0, MS = 1, MC = 2, ML = 3, MX = 4;
  int m_mode = MI, m_val = 0, m_n = 0, m_sk = 0, m_loaded = 0, m_err = 0;
  int m_fail = 0, m_cyc = 0, m_exit = 0;

  function automatic int sat_inc(input int f);
    return (f >= 15) ? 15 : f + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= MI; m_val <= 0; m_n <= 0; m_sk <= 0; m_loaded <= 0;
      m_err <= 0; m_fail <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      m_err <= 0;
      case (m_mode)
        MI, ML: if (ks) begin m_val <= 0; m_n <= 0; m_mode <= MS; end
        MS: begin
          if (ks) begin m_val <= 0; m_n <= 0; end
          else if (m_n == KW + 1) m_mode <= MC;
          else if (kv) begin m_val <= m_val * 2 + int'(kb); m_n <= m_n + 1; end
        end
        MC: begin
          if ($countones(m_val) % 2 == 0) begin
            m_sk <= m_val / 2; m_loaded <= 1; m_fail <= 0; m_mode <= ML;
          end else begin
            m_err <= 1;
            m_fail <= sat_inc(m_fail);
            if (sat_inc(m_fail) == FM) begin
              m_mode <= MX; m_sk <= 0; m_loaded <= 0; m_exit <= m_cyc + LC;
            end else m_mode <= (m_loaded != 0) ? ML : MI;
          end
        end
        MX: if (m_cyc == m_exit) begin m_fail <= 0; m_mode <= MI; end
        default: m_mode <= MI;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("key_ready", 32'(key_ready), 32'(m_mode == MI || m_mode == MS || m_mode == ML));
    chk("sk", 32'(sk), 32'(m_sk));
    chk("key_loaded", 32'(key_loaded), 32'(m_loaded));
    chk("key_err", 32'(key_err), 32'(m_err));
    chk("lockout", 32'(lockout), 32'(m_mode == MX));
    chk("core_enable", 32'(core_enable), 32'(en & (m_loaded != 0)));
  end

  task automatic step(input logic s, input logic v, input logic b);
    ks = s; kv = v; kb = b;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [3:0] k, input logic p, input logic gap);
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 1'b1, k[i]);
      if (gap) step(1'b0, 1'b0, 1'($urandom));
    end
    step(1'b0, 1'b1, p);
    ks = 1'b0; kv = 1'b0;
  endtask

  task automatic commit();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst_n = 1'b0;
    ks = 1'b0; kv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [3:0] k;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(key_ready), 32'd1);
    chk("rst_sk", 32'(sk), 32'd0);
    chk("rst_loaded", 32'(key_loaded), 32'd0);
    rst_n = 1'b1;

    // Good frame 1011 p=1
    en = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    send(4'b1011, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_check_ready", 32'(key_ready), 32'd0);
    chk("t1_sk_pending", 32'(sk), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_sk", 32'(sk), 32'hB);
    chk("t1_loaded", 32'(key_loaded), 32'd1);
    chk("t1_core_en", 32'(core_enable), 32'd1);

    // Bad frame from fresh reset
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    send(4'b1011, 1'b0, 1'b0);
    commit();
    chk("t2_err", 32'(key_err), 32'd1);
    chk("t2_sk", 32'(sk), 32'd0);
    chk("t2_loaded", 32'(key_loaded), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("t2_err_pulse", 32'(key_err), 32'd0);
    chk("t2_ready", 32'(key_ready), 32'd1);

    // Good 0110 then three bad frames -> lockout
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    send(4'b0110, 1'b0, 1'b0);
    commit();
    chk("t3_sk", 32'(sk), 32'h6);
    for (int f = 0; f < 3; f++) begin
      step(1'b1, 1'b0, 1'b0);
      send(4'b0110, 1'b1, 1'b0);
      commit();
      chk("t3_err", 32'(key_err), 32'd1);
      if (f < 2) chk("t3_still_loaded", 32'(key_loaded), 32'd1);
    end
    chk("t3_lockout", 32'(lockout), 32'd1);
    chk("t3_zero_sk", 32'(sk), 32'd0);
    chk("t3_zero_loaded", 32'(key_loaded), 32'd0);
    chk("t3_core_en", 32'(core_enable), 32'd0);
    n = 0;
    while (lockout && n < 40) begin
      n++;
      step(1'b1, 1'b1, 1'b1);
    end
    chk("t3_lock_len", 32'(n), 32'(LC));
    step(1'b1, 1'b0, 1'b0);
    send(4'b1001, 1'b0, 1'b0);
    commit();
    chk("t3_after_sk", 32'(sk), 32'h9);

    // Reload with gapped valid
    step(1'b1, 1'b0, 1'b0);
    send(4'b0110, 1'b0, 1'b0);
    commit();
    step(1'b1, 1'b0, 1'b0);
    send(4'b0011, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("t4_sk_hold", 32'(sk), 32'h6);
    chk("t4_core_en", 32'(core_enable), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("t4_sk_new", 32'(sk), 32'h3);

    // Restart after two bits
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    send(4'b1111, 1'b0, 1'b0);
    commit();
    chk("t5_sk", 32'(sk), 32'hF);

    // Async reset mid-frame
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_sk", 32'(sk), 32'd0);
    chk("t6_loaded", 32'(key_loaded), 32'd0);
    chk("t6_core_en", 32'(core_enable), 32'd0);
    chk("t6_ready", 32'(key_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    kv = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    chk("t6_ready_after", 32'(key_ready), 32'd1);

    // Randomized frames with noise
    for (int it = 0; it < 200; it++) begin
      en = 1'($urandom);
      k = 4'($urandom);
      step(1'b1, 1'($urandom), 1'($urandom));
      send(k, (^k) ^ ($urandom_range(0, 2) == 0), 1'($urandom));
      repeat ($urandom_range(0, 4))
        step($urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom));
    end
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 50) == 0) en = ~en;
      step($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, 1'($urandom));
    end
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
